alu_control_stage: RTL and testbench

ALU_CONTROL_STAGE -- requirements
Module: alu_control_stage

---
 rtl/alu_control_stage_pkg.sv | 51 +++++
 rtl/alu_op_decoder.sv | 67 ++++++
 rtl/alu_control_stage.sv | 118 +++++++++++
 tb/tb_alu_control_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_control_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_stage_pkg
// Description : Shared MIPS constants: ALU operator codes, main-control
//               alu_op classes, R-type funct and I-type opcode values, and
//               the decoded-word struct carried through the skid buffer.
//               Also used by the ALU and the main control.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_control_stage_pkg;

    // ALU operator codes
    localparam logic [3:0] c_op_and     = 4'b0000;
    localparam logic [3:0] c_op_or      = 4'b0001;
    localparam logic [3:0] c_op_add     = 4'b0010;
    localparam logic [3:0] c_op_sub     = 4'b0110;
    localparam logic [3:0] c_op_slt     = 4'b0111;
    localparam logic [3:0] c_op_nor     = 4'b1100;
    localparam logic [3:0] c_op_illegal = 4'b1111;

    // Main-control alu_op classes
    localparam logic [1:0] c_aluop_mem    = 2'b00;
    localparam logic [1:0] c_aluop_branch = 2'b01;
    localparam logic [1:0] c_aluop_rtype  = 2'b10;
    localparam logic [1:0] c_aluop_imm    = 2'b11;

    // R-type funct field values
    localparam logic [5:0] c_funct_add  = 6'b100000;
    localparam logic [5:0] c_funct_addu = 6'b100001;
    localparam logic [5:0] c_funct_sub  = 6'b100010;
    localparam logic [5:0] c_funct_subu = 6'b100011;
    localparam logic [5:0] c_funct_and  = 6'b100100;
    localparam logic [5:0] c_funct_or   = 6'b100101;
    localparam logic [5:0] c_funct_nor  = 6'b100111;
    localparam logic [5:0] c_funct_slt  = 6'b101010;

    // I-type opcode values
    localparam logic [5:0] c_opc_addi  = 6'b001000;
    localparam logic [5:0] c_opc_addiu = 6'b001001;
    localparam logic [5:0] c_opc_slti  = 6'b001010;
    localparam logic [5:0] c_opc_andi  = 6'b001100;
    localparam logic [5:0] c_opc_ori   = 6'b001101;

    // One decoded word as held in the output and skid registers
    typedef struct packed {
        logic [3:0] operator;
        logic       illegal;
    } alu_word_t;

endpackage : alu_control_stage_pkg
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decoder
// Description : Purely combinational ALU control decode.
//   alu_op   [1:0] in  : main-control class (mem/branch/R-type/immediate)
//   funct    [5:0] in  : funct field, meaningful for R-type
//   opcode   [5:0] in  : opcode field, meaningful for immediate class
//   operator [3:0] out : ALU operator code (1111 when undecodable)
//   illegal        out : 1 when no legal operation matched
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decoder
    import alu_control_stage_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    output logic [3:0] operator,
    output logic       illegal
);

    always_comb begin
        // Default to the illegal encoding; each legal arm overrides it.
        operator = c_op_illegal;
        illegal  = 1'b1;
        case (alu_op)
            c_aluop_mem: begin
                operator = c_op_add;
                illegal  = 1'b0;
            end
            c_aluop_branch: begin
                operator = c_op_sub;
                illegal  = 1'b0;
            end
            c_aluop_rtype: begin
                illegal = 1'b0;
                case (funct)
                    c_funct_add, c_funct_addu: operator = c_op_add;
                    c_funct_sub, c_funct_subu: operator = c_op_sub;
                    c_funct_and:               operator = c_op_and;
                    c_funct_or:                operator = c_op_or;
                    c_funct_nor:               operator = c_op_nor;
                    c_funct_slt:               operator = c_op_slt;
                    default: begin
                        operator = c_op_illegal;
                        illegal  = 1'b1;
                    end
                endcase
            end
            default: begin // c_aluop_imm
                illegal = 1'b0;
                case (opcode)
                    c_opc_addi, c_opc_addiu: operator = c_op_add;
                    c_opc_andi:              operator = c_op_and;
                    c_opc_ori:               operator = c_op_or;
                    c_opc_slti:              operator = c_op_slt;
                    default: begin
                        operator = c_op_illegal;
                        illegal  = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule : alu_op_decoder
`default_nettype wire

// File: rtl/alu_control_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_stage
// Description : ALU control decode followed by a two-entry skid buffer
//               (output register + skid register) with a registered
//               in_ready, synchronous flush and a saturating counter of
//               accepted illegal words.
//   clock, reset_n          : clock, asynchronous active-low reset
//   in_valid / in_ready     : upstream handshake (in_ready registered)
//   alu_op, funct, opcode   : decode inputs
//   flush                   : drop all held words at the next edge
//   out_valid / out_ready   : downstream handshake
//   operator, illegal       : decoded word presented downstream
//   err_count               : saturating count of accepted illegal words
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_stage
    import alu_control_stage_pkg::*;
#(
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               alu_op,
    input  logic [5:0]               funct,
    input  logic [5:0]               opcode,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               operator,
    output logic                     illegal,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    alu_word_t w_dec;

    alu_op_decoder u_decoder (
        .alu_op   (alu_op),
        .funct    (funct),
        .opcode   (opcode),
        .operator (w_dec.operator),
        .illegal  (w_dec.illegal)
    );

    alu_word_t                r_out_word;
    logic                     r_out_valid;
    alu_word_t                r_skid_word;
    logic                     r_skid_valid;
    logic                     r_in_ready;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    logic w_accept;
    logic w_slot_free;
    logic w_store;

    // A handshake counts as an accept even when flush discards the word,
    // so the illegal counter still sees it.
    assign w_accept    = in_valid & r_in_ready;
    assign w_store     = w_accept & ~flush;
    // Output register may be overwritten when empty or being consumed.
    assign w_slot_free = ~r_out_valid | out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_word   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_word  <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_slot_free) begin
            if (r_skid_valid) begin
                // Skid drains first to preserve order; a new word takes its place.
                r_out_word   <= r_skid_word;
                r_out_valid  <= 1'b1;
                r_skid_valid <= w_store;
                r_in_ready   <= ~w_store;
                if (w_store) begin
                    r_skid_word <= w_dec;
                end
            end else begin
                r_out_valid <= w_store;
                r_in_ready  <= 1'b1;
                if (w_store) begin
                    r_out_word <= w_dec;
                end
            end
        end else if (w_store) begin
            // Output stalled: in_ready=1 guarantees the skid is empty here.
            r_skid_word  <= w_dec;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end else begin
            r_in_ready <= ~r_skid_valid;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (w_accept && w_dec.illegal && !(&r_err_count)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign operator  = r_out_word.operator;
    assign illegal   = r_out_word.illegal;
    assign err_count = r_err_count;

endmodule : alu_control_stage
`default_nettype wire

// File: tb/tb_alu_control_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_stage
// Description : Directed self-checking bench for alu_control_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_stage;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] alu_op = 2'b00;
    logic [5:0] funct = 6'b0;
    logic [5:0] opcode = 6'b0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] operator;
    logic       illegal;
    logic [7:0] err_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    alu_control_stage #(.ERR_CNT_WIDTH(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .opcode    (opcode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operator  (operator),
        .illegal   (illegal),
        .err_count (err_count)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (operator !== 4'b0000) $display("FAIL rst_operator got %b want 0000", operator); else pass_cnt++;
        total_cnt++; if (illegal !== 1'b0) $display("FAIL rst_illegal got %b want 0", illegal); else pass_cnt++;
        total_cnt++; if (err_count !== 8'd0) $display("FAIL rst_err_count got %0d want 0", err_count); else pass_cnt++;
        step();
        reset_n = 1'b1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_release_in_ready got %b want 0", in_ready); else pass_cnt++;
        step();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL first_edge_in_ready got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_rtype_stream();
        logic [5:0] f_tab [4] = '{6'b100100, 6'b100101, 6'b101010, 6'b100111};
        logic [3:0] e_tab [4] = '{4'b0000, 4'b0001, 4'b0111, 4'b1100};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = 2'b10;
        for (int i = 0; i < 4; i++) begin
            funct = f_tab[i];
            step();
            total_cnt++; if (out_valid !== 1'b1 || operator !== e_tab[i] || illegal !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL rtype_%0d got v=%b op=%b ill=%b rdy=%b want v=1 op=%b ill=0 rdy=1",
                         i, out_valid, operator, illegal, in_ready, e_tab[i]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rtype_drain got v=%b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 2'b00;
        step();
        total_cnt++; if (out_valid !== 1'b1 || operator !== 4'b0010 || in_ready !== 1'b1)
            $display("FAIL bp_first got v=%b op=%b rdy=%b want v=1 op=0010 rdy=1", out_valid, operator, in_ready);
        else pass_cnt++;
        alu_op = 2'b01;
        step();
        total_cnt++; if (in_ready !== 1'b0 || operator !== 4'b0010)
            $display("FAIL bp_full got rdy=%b op=%b want rdy=0 op=0010", in_ready, operator);
        else pass_cnt++;
        alu_op = 2'b10;
        funct  = 6'b100101;
        step();
        total_cnt++; if (in_ready !== 1'b0 || operator !== 4'b0010 || out_valid !== 1'b1)
            $display("FAIL bp_hold got rdy=%b op=%b v=%b want rdy=0 op=0010 v=1", in_ready, operator, out_valid);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        total_cnt++; if (operator !== 4'b0110 || out_valid !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL bp_skid_drain got op=%b v=%b rdy=%b want op=0110 v=1 rdy=1", operator, out_valid, in_ready);
        else pass_cnt++;
        step();
        total_cnt++; if (operator !== 4'b0001 || out_valid !== 1'b1)
            $display("FAIL bp_third got op=%b v=%b want op=0001 v=1", operator, out_valid);
        else pass_cnt++;
        in_valid = 1'b0;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty got v=%b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_immediate();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = 2'b11;
        opcode    = 6'b001101;
        step();
        total_cnt++; if (operator !== 4'b0001 || illegal !== 1'b0 || err_count !== 8'd0)
            $display("FAIL imm_ori got op=%b ill=%b err=%0d want op=0001 ill=0 err=0", operator, illegal, err_count);
        else pass_cnt++;
        opcode = 6'b000100;
        step();
        total_cnt++; if (operator !== 4'b1111 || illegal !== 1'b1 || err_count !== 8'd1)
            $display("FAIL imm_illegal got op=%b ill=%b err=%0d want op=1111 ill=1 err=1", operator, illegal, err_count);
        else pass_cnt++;
        alu_op = 2'b10;
        funct  = 6'b000000;
        step();
        total_cnt++; if (operator !== 4'b1111 || illegal !== 1'b1 || err_count !== 8'd2)
            $display("FAIL rtype_illegal got op=%b ill=%b err=%0d want op=1111 ill=1 err=2", operator, illegal, err_count);
        else pass_cnt++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 2'b00;
        step();
        alu_op = 2'b01;
        step();
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_prefill got rdy=%b want 0", in_ready); else pass_cnt++;
        flush  = 1'b1;
        alu_op = 2'b11;
        opcode = 6'b111111;
        step();
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== 8'd2)
            $display("FAIL flush_clear got v=%b rdy=%b err=%0d want v=0 rdy=1 err=2", out_valid, in_ready, err_count);
        else pass_cnt++;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_nothing_out got v=%b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = 2'b10;
        funct     = 6'b111111;
        for (int i = 0; i < 260; i++) begin
            step();
        end
        total_cnt++; if (err_count !== 8'd255 || illegal !== 1'b1)
            $display("FAIL err_saturate got err=%0d ill=%b want err=255 ill=1", err_count, illegal);
        else pass_cnt++;
        in_valid = 1'b0;
        step();
        total_cnt++; if (err_count !== 8'd255) $display("FAIL err_hold got %0d want 255", err_count); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 2'b11;
        opcode    = 6'b001100;
        step();
        opcode = 6'b001101;
        step();
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL mid_prefill got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || operator !== 4'b0000 || err_count !== 8'd0)
            $display("FAIL mid_async got v=%b rdy=%b op=%b err=%0d want v=0 rdy=0 op=0000 err=0",
                     out_valid, in_ready, operator, err_count);
        else pass_cnt++;
        #2;
        reset_n = 1'b1;
        step();
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL mid_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        else pass_cnt++;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = 2'b01;
        step();
        total_cnt++; if (out_valid !== 1'b1 || operator !== 4'b0110)
            $display("FAIL mid_first_word got v=%b op=%b want v=1 op=0110", out_valid, operator);
        else pass_cnt++;
        in_valid = 1'b0;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_no_stale got v=%b want 0", out_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rtype_stream();
        test_backpressure();
        test_immediate();
        test_flush();
        test_saturate();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_alu_control_stage
`default_nettype wire
